// File: rtl/mvu_mem_pkg.sv
// rtl/mvu_mem_pkg.sv - shared constants and types for the 512x16 scratch memory
package mvu_mem_pkg;

  localparam int MEM_AW      = 9;
  localparam int MEM_DW      = 16;
  localparam int SRAM_RD_LAT = 1;
  localparam int BANK_MSB    = 8;
  localparam int BANK_LSB    = 7;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  function automatic logic [BANK_MSB-BANK_LSB:0] bank_sel(input logic [MEM_AW-1:0] addr);
    return addr[BANK_MSB:BANK_LSB];
  endfunction

endpackage

// File: rtl/tp_stream_fifo.sv
// rtl/tp_stream_fifo.sv - small output buffer with occupancy count
module tp_stream_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A push into a full buffer without a matching pop means the issue credit is broken.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && count == CW'(DEPTH)))
        else $error("tp_stream_fifo overflow");
    end
  end

endmodule

// File: rtl/tp_mem_rd_streamer.sv
// rtl/tp_mem_rd_streamer.sv - strided burst reader for the two-port scratch memory
module tp_mem_rd_streamer
  import mvu_mem_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int RD_LAT     = SRAM_RD_LAT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW:0]   cmd_len,
  input  logic [AW-1:0] cmd_stride,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_word,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  rd_state_t         state;
  logic [AW-1:0]     addr;
  logic [AW-1:0]     stride;
  logic [AW:0]       issue_left;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_l;
  logic [CW-1:0]     fifo_count;
  logic [DW:0]       fifo_head;
  logic              fifo_empty;
  logic              pop;
  logic              last_issue;
  logic [31:0]       inflight;
  logic [31:0]       credit_used;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 32'(pipe_v[i]);
  end

  // Words already buffered or in the SRAM pipe must leave room for this read.
  assign pop         = out_valid & out_ready;
  assign credit_used = 32'(fifo_count) + inflight - 32'(pop);
  assign rd_en       = (state == RD_ISSUE) && (issue_left != '0) &&
                       (credit_used < 32'(FIFO_DEPTH));
  assign last_issue  = rd_en && (issue_left == (AW+1)'(1));
  assign rd_addr     = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RD_IDLE;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr       <= '0;
      stride     <= '0;
      issue_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state      <= RD_ISSUE;
              busy       <= 1'b1;
              addr       <= cmd_base;
              stride     <= cmd_stride;
              issue_left <= cmd_len;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RD_ISSUE: begin
          if (rd_en) begin
            addr       <= addr + stride;
            issue_left <= issue_left - 1'b1;
            if (last_issue) state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (pop && out_last) begin
            state <= RD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      pipe_l <= '0;
    end else begin
      pipe_v[0] <= rd_en;
      pipe_l[0] <= last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_l[i] <= pipe_l[i-1];
      end
    end
  end

  tp_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DW+1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_v[RD_LAT-1]),
    .push_data ({pipe_l[RD_LAT-1], rd_word}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_word  = fifo_head[DW-1:0];
  assign out_last  = fifo_head[DW];

endmodule
